// File: rtl/registry_pkg.sv
// ============================================================================
// registry_pkg : shared constants and types for the multi-port register file
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package registry_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned REG_DEPTH = 32;

  typedef logic [$clog2(REG_DEPTH)-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]         reg_data_t;

endpackage

`default_nettype wire

// File: rtl/registry_scoreboard.sv
// ============================================================================
// registry_scoreboard : per-register busy bits with reserve-over-clear priority
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module registry_scoreboard
  import registry_pkg::*;
#(
  parameter int unsigned DEPTH = REG_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DEPTH-1:0]             wr_clr_i,
  input  logic                         rsv_en_i,
  input  logic [$clog2(DEPTH)-1:0]     rsv_addr_i,
  output logic [DEPTH-1:0]             busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   busy_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The reserve is applied after the clear so a new producer wins over writeback.
  always_comb begin
    busy_d = busy_q & ~wr_clr_i;
    if (rsv_en_i && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      cnt_d = cnt_d + CW'(busy_d[a]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/registry_mp.sv
// ============================================================================
// registry_mp : multi-port register file with write priority, bypass, scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registry_mp
  import registry_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]   rs_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]           rd_data,
  output logic [NUM_RD-1:0]                      rd_busy,
  input  logic [NUM_WR-1:0]                      wr_en,
  input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]           wr_data,
  input  logic                                   rsv_en,
  input  logic [$clog2(DEPTH)-1:0]               rsv_addr,
  output logic [$clog2(DEPTH+1)-1:0]             busy_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] busy;

  // Ports are scanned in ascending order so the highest-index writer wins.
  always_comb begin
    wr_hit = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      wr_val[a] = '0;
    end
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_addr[j]] = 1'b1;
        wr_val[wr_addr[j]] = wr_data[j];
      end
    end
    wr_hit[0] = 1'b0;
    wr_val[0] = '0;
  end

  always_comb begin
    for (int unsigned a = 0; a < DEPTH; a++) begin
      regs_d[a] = wr_hit[a] ? wr_val[a] : regs_q[a];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  registry_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_clr_i   (wr_hit),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt)
  );

  // Register 0 never stores data, never hits and is never busy, so it reads as 0/0.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i] = regs_q[rs_addr[i]];
      rd_busy[i] = busy[rs_addr[i]];
      if (BYPASS && wr_hit[rs_addr[i]]) begin
        rd_data[i] = wr_val[rs_addr[i]];
        rd_busy[i] = rsv_en && (rsv_addr == rs_addr[i]);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_registry_mp.sv
// Directed table-driven bench for registry_mp; a BYPASS=0 twin shares all inputs.
`default_nettype none

module tb_registry_mp;
  import registry_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0][4:0]      rs_addr;
  logic [1:0][31:0]     rd_data, nb_rd_data;
  logic [1:0]           rd_busy, nb_rd_busy;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][31:0]     wr_data;
  logic                 rsv_en;
  reg_addr_t            rsv_addr;
  logic [5:0]           busy_cnt, nb_busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  registry_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  registry_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(nb_busy_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ren;
    logic [4:0]  ra;
    logic [4:0]  rs0, rs1;
    logic        chk;
    logic [31:0] d0, d1;
    logic        b0, b1;
    logic [5:0]  cnt;
    logic [31:0] nd0;
    logic        nb0;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(
    input logic rst, input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1, input logic ren, input logic [4:0] ra,
    input logic [4:0] rs0, input logic [4:0] rs1, input logic chk,
    input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1,
    input logic [5:0] cnt, input logic [31:0] nd0, input logic nb0);
    vec_t v;
    v.rst_n = rst; v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ren = ren; v.ra = ra; v.rs0 = rs0; v.rs1 = rs1; v.chk = chk;
    v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1; v.cnt = cnt; v.nd0 = nd0; v.nb0 = nb0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] wen, input logic [4:0] wa0,
                       input logic [31:0] wd0, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ren, input logic [4:0] ra, input logic [4:0] rs0,
                       input logic [4:0] rs1);
    rst_n = rst; wr_en = wen; wr_addr[0] = wa0; wr_data[0] = wd0;
    wr_addr[1] = wa1; wr_data[1] = wd1; rsv_en = ren; rsv_addr = ra;
    rs_addr[0] = rs0; rs_addr[1] = rs1;
  endtask

  initial begin
    //            rst wen    wa0 wd0           wa1 wd1 ren ra  rs0 rs1 chk d0            b0 d1            b1 cnt nd0           nb0
    vecs[0]  = mk(0, 2'b00, 0, 0,            0, 0, 0, 0,  0,  0,  0, 0,            0, 0,            0, 0,  0,            0);
    vecs[1]  = mk(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5,  5,  0,  1, 32'hDEADBEEF, 1, 0,            0, 0,  0,            0);
    vecs[2]  = mk(0, 2'b00, 0, 0,            0, 0, 0, 0,  5,  0,  1, 32'hDEADBEEF, 1, 0,            0, 1,  32'hDEADBEEF, 1);
    vecs[3]  = mk(0, 2'b00, 0, 0,            0, 0, 0, 0,  5,  0,  1, 0,            0, 0,            0, 0,  0,            0);
    vecs[4]  = mk(1, 2'b01, 0, 32'h1234,     0, 0, 1, 0,  0,  5,  1, 0,            0, 0,            0, 0,  0,            0);
    vecs[5]  = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  0,  5,  1, 0,            0, 0,            0, 0,  0,            0);
    vecs[6]  = mk(1, 2'b11, 3, 7,            3, 9, 0, 0,  3,  4,  1, 9,            0, 0,            0, 0,  0,            0);
    vecs[7]  = mk(1, 2'b11, 4, 1,            6, 2, 0, 0,  3,  4,  1, 9,            0, 1,            0, 0,  9,            0);
    vecs[8]  = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  4,  6,  1, 1,            0, 2,            0, 0,  1,            0);
    vecs[9]  = mk(1, 2'b01, 2, 4,            0, 0, 0, 0,  2,  6,  1, 4,            0, 2,            0, 0,  0,            0);
    vecs[10] = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  2,  3,  1, 4,            0, 9,            0, 0,  4,            0);
    vecs[11] = mk(1, 2'b00, 0, 0,            0, 0, 1, 7,  7,  2,  1, 0,            0, 4,            0, 0,  0,            0);
    vecs[12] = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  7,  2,  1, 0,            1, 4,            0, 1,  0,            1);
    vecs[13] = mk(1, 2'b10, 0, 0,            7, 11, 0, 0, 7,  2,  1, 11,           0, 4,            0, 1,  0,            1);
    vecs[14] = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  7,  6,  1, 11,           0, 2,            0, 0,  11,           0);
    vecs[15] = mk(1, 2'b01, 7, 11,           0, 0, 1, 7,  7,  0,  1, 11,           1, 0,            0, 0,  11,           0);
    vecs[16] = mk(1, 2'b00, 0, 0,            0, 0, 0, 0,  7,  0,  1, 11,           1, 0,            0, 1,  11,           1);

    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      drive(vecs[k].rst_n, vecs[k].wen, vecs[k].wa0, vecs[k].wd0, vecs[k].wa1, vecs[k].wd1,
            vecs[k].ren, vecs[k].ra, vecs[k].rs0, vecs[k].rs1);
      @(negedge clk);
      if (vecs[k].chk) begin
        check($sformatf("v%0d rd_data0", k), rd_data[0], vecs[k].d0);
        check($sformatf("v%0d rd_busy0", k), 32'(rd_busy[0]), 32'(vecs[k].b0));
        check($sformatf("v%0d rd_data1", k), rd_data[1], vecs[k].d1);
        check($sformatf("v%0d rd_busy1", k), 32'(rd_busy[1]), 32'(vecs[k].b1));
        check($sformatf("v%0d busy_cnt", k), 32'(busy_cnt), 32'(vecs[k].cnt));
        check($sformatf("v%0d nb rd_data0", k), nb_rd_data[0], vecs[k].nd0);
        check($sformatf("v%0d nb rd_busy0", k), 32'(nb_rd_busy[0]), 32'(vecs[k].nb0));
      end
    end

    // Capacity: reserve x1..x31 one per cycle; count grows by one each edge.
    @(posedge clk); #1;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 1; r < 32; r++) begin
      @(posedge clk); #1;
      drive(1, 2'b00, 0, 0, 0, 0, 1, 5'(r), 5'(r), 0);
      @(negedge clk);
      check($sformatf("cap cnt before x%0d", r), 32'(busy_cnt), 32'(r - 1));
    end
    @(posedge clk); #1;
    drive(1, 2'b00, 0, 0, 0, 0, 1, 5, 5, 31);
    @(negedge clk);
    check("cap cnt full", 32'(busy_cnt), 32'd31);
    check("cap nb cnt full", 32'(nb_busy_cnt), 32'd31);
    check("cap busy x5", 32'(rd_busy[0]), 32'd1);
    check("cap busy x31", 32'(rd_busy[1]), 32'd1);
    @(posedge clk); #1;
    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    check("cap cnt after re-reserve", 32'(busy_cnt), 32'd31);
    check("cap busy x0", 32'(rd_busy[1]), 32'd0);
    @(posedge clk); #1;
    drive(0, 2'b00, 0, 0, 0, 0, 1, 9, 5, 0);
    @(negedge clk);
    check("cap cnt during reset", 32'(busy_cnt), 32'd31);
    @(posedge clk); #1;
    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 5);
    @(negedge clk);
    check("cap cnt after reset", 32'(busy_cnt), 32'd0);
    check("cap busy x9 after reset", 32'(rd_busy[0]), 32'd0);
    check("cap busy x5 after reset", 32'(rd_busy[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/registry_mp.md
Name: registry_mp

Overview:
- Parametrised, multi-port successor to the single-write, dual-read integer register file of the RV32I core.
- Adds the following:
  - configurable width, depth and read-port count;
  - NUM_WR write ports with a fixed priority order;
  - optional write-through bypass;
  - a per-register busy scoreboard for pipelined hazard detection;
  - a synchronous clear on reset.
- Sits between decode (read addresses, destination reservation) and writeback (write ports).

Parameters:
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; must be a power of two and at least 2
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = read returns stored value only

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- rs_addr  in  NUM_RD x AW  read addresses, where AW = $clog2(DEPTH)
- rd_data  out  NUM_RD x WIDTH  read data
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR x AW  write addresses
- wr_data  in  NUM_WR x WIDTH  write data
- rsv_en  in  1  reserve request: mark a destination as busy
- rsv_addr  in  AW  destination to reserve
- busy_cnt  out  $clog2(DEPTH+1)  number of registers currently busy

Behaviour:
- Reset: clk edge with rst_n=0 clears every register and every busy bit to 0; busy_cnt=0. The reset edge overrides any same-cycle write or reserve. Reset mid-operation discards all pending reservations.
- Register 0 is hardwired:
  - reads return 0 with rd_busy=0;
  - writes to address 0 are ignored;
  - reserves of address 0 are ignored.
- Read path is combinational, with zero latency from rs_addr to rd_data and rd_busy.
- Write: at a clk edge, reg[wr_addr[j]] <= wr_data[j] for each j with wr_en[j]=1.
  - If several ports target the same address, the highest index j wins.
  - Writes to distinct addresses all commit in the same cycle.
- Bypass, BYPASS=1:
  - If any wr_en[j] is set and wr_addr[j]==rs_addr[i]!=0, rd_data[i] = wr_data of the winning port.
  - In that case rd_busy[i] = 1 only if the same cycle also reserves that address (rsv_en && rsv_addr==rs_addr[i]); otherwise 0.
- No bypass, BYPASS=0: rd_data[i] = stored value and rd_busy[i] = stored busy bit, ignoring same-cycle activity.
- Scoreboard, updated each clk edge per address a≠0:
  - A write to a clears busy[a].
  - rsv_en with rsv_addr==a sets busy[a].
  - Simultaneous write and reserve to the same a: the reserve wins, so busy[a]=1 and the data is still written. This represents a new producer in flight.
  - Reserving an already-busy register keeps it busy; there is no counting.
  - A write to a non-busy register is legal and leaves it non-busy.
- busy_cnt:
  - a registered population count of the busy bits, always equal to the count after the current edge;
  - it never exceeds DEPTH-1, since register 0 is never busy.
- Data is stored full-width. No sign or zero handling; the register file is transparent to data.
- No X propagation: every output is defined from the first post-reset cycle.

Decomposition:
- registry_pkg holds the following:
  - default constants REG_WIDTH=32 and REG_DEPTH=32;
  - the address typedef reg_addr_t (logic [$clog2(REG_DEPTH)-1:0]);
  - the data typedef reg_data_t.
- Sub-module registry_scoreboard:
  - owns the busy bit vector, the set/clear priority logic and the busy_cnt popcount;
  - takes the winning per-address write-clear vector and the reserve request, and provides the busy vector.
- registry_mp instantiates registry_scoreboard and contains the storage array, write-priority logic and read/bypass muxes.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles after writes of 0xDEADBEEF to x5 and a reserve of x5, then read x5 -> rd_data=0, rd_busy=0, busy_cnt=0.
- x0 protection: write 0x1234 to x0 on port 0 and reserve x0, then read x0 -> rd_data=0, rd_busy=0, busy_cnt=0.
- Write priority: same cycle, port0 writes x3=7 and port1 writes x3=9; next cycle read x3 -> 9. Same cycle with port0 x4=1 and port1 x6=2 -> x4=1 and x6=2.
- Bypass, BYPASS=1: write x2=4 while rs_addr[0]=2 in the same cycle -> rd_data[0]=4 before the edge. With BYPASS=0 -> old value 0 until the edge, then 4.
- Scoreboard: reserve x7 -> rd_busy=1, busy_cnt=1. Write x7=11 -> busy clears, busy_cnt=0. Simultaneous reserve and write to x7 -> busy stays 1, x7=11 stored.
- Capacity: reserve x1..x31 on successive cycles -> busy_cnt=31. Re-reserve x5 -> still 31. Reset -> 0.
